// File: rtl/issue_queue_pkg.sv
// Shared widths, renamed-op field positions and entry layout for the issue queue.
// Every other issue_queue file imports this package.
package issue_queue_pkg;

  localparam int RENAMED_OP_SZ = 52;
  localparam int PR_ADDR_W     = 5;
  localparam int OP_SRC_LSB    = 13;
  localparam int OP_NUM_SRC    = 4;
  localparam int OP_ROB_LSB    = 38;
  localparam int OP_OPCODE_LSB = 44;
  localparam int SRCS_W        = OP_NUM_SRC * PR_ADDR_W;

  localparam logic [PR_ADDR_W-1:0] PR_NULL = '0;

  typedef struct packed {
    logic [RENAMED_OP_SZ-1:0] instr;
    logic [7:0]               arch_dest;
  } iq_entry_t;

  // All four physical source fields, source k at bits [k*PR_ADDR_W +: PR_ADDR_W].
  function automatic logic [SRCS_W-1:0] op_srcs(input logic [RENAMED_OP_SZ-1:0] op);
    return op[OP_SRC_LSB +: SRCS_W];
  endfunction

endpackage

// File: rtl/iq_wakeup.sv
// Source-ready tracking for one queue entry: selects which op the slot will hold
// next edge (own, shifted-in neighbour, or new insert) and ORs in matching writebacks.
module iq_wakeup
  import issue_queue_pkg::*;
#(
  parameter int NUM_WB = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_flush,
  input  logic                        i_load,
  input  logic                        i_shift,
  input  logic [SRCS_W-1:0]           i_cur_srcs,
  input  logic [SRCS_W-1:0]           i_up_srcs,
  input  logic [OP_NUM_SRC-1:0]       i_up_rdy,
  input  logic [SRCS_W-1:0]           i_new_srcs,
  input  logic [OP_NUM_SRC-1:0]       i_new_rdy,
  input  logic [PR_ADDR_W*NUM_WB-1:0] i_wb_addrs,
  input  logic [NUM_WB-1:0]           i_wb_valid,
  output logic [OP_NUM_SRC-1:0]       o_rdy
);

  logic [OP_NUM_SRC-1:0] r_rdy;
  logic [SRCS_W-1:0]     w_base_srcs;
  logic [OP_NUM_SRC-1:0] w_base_rdy;
  logic [OP_NUM_SRC-1:0] w_match;
  logic [OP_NUM_SRC-1:0] w_nxt_rdy;

  // Compare against the op that will occupy this slot after the edge, so a
  // wakeup coinciding with a shift or insert lands on the right entry.
  always_comb begin
    w_base_srcs = i_cur_srcs;
    w_base_rdy  = r_rdy;
    if (i_load) begin
      w_base_srcs = i_new_srcs;
      w_base_rdy  = i_new_rdy;
    end else if (i_shift) begin
      w_base_srcs = i_up_srcs;
      w_base_rdy  = i_up_rdy;
    end
  end

  always_comb begin
    w_match = '0;
    for (int k = 0; k < OP_NUM_SRC; k++) begin
      if (w_base_srcs[k*PR_ADDR_W +: PR_ADDR_W] == PR_NULL) w_match[k] = 1'b1;
      for (int j = 0; j < NUM_WB; j++) begin
        if (i_wb_valid[j] &&
            (i_wb_addrs[j*PR_ADDR_W +: PR_ADDR_W] == w_base_srcs[k*PR_ADDR_W +: PR_ADDR_W]))
          w_match[k] = 1'b1;
      end
    end
    w_nxt_rdy = w_base_rdy | w_match;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) r_rdy <= '0;
    else                r_rdy <= w_nxt_rdy;
  end

  assign o_rdy = r_rdy;

endmodule

// File: rtl/issue_queue.sv
// Compacting age-ordered issue queue: entry 0 is oldest, valid entries are contiguous.
// Handshakes: a transfer happens on a clock edge where both valid and ready are high.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int NUM_WB   = 6,
  parameter int IN_ORDER = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [RENAMED_OP_SZ-1:0]     in_instr,
  input  logic [7:0]                   in_arch_dest,
  input  logic [OP_NUM_SRC-1:0]        in_src_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PR_ADDR_W*NUM_WB-1:0]  wb_addrs,
  input  logic [NUM_WB-1:0]            wb_valid,
  output logic [RENAMED_OP_SZ-1:0]     out_instr,
  output logic [7:0]                   out_arch_dest,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  iq_entry_t             r_ent   [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [CW-1:0]         r_count;

  iq_entry_t             w_up_ent    [DEPTH];
  logic [DEPTH-1:0]      w_up_valid;
  logic [OP_NUM_SRC-1:0] w_rdy       [DEPTH];
  logic [OP_NUM_SRC-1:0] w_up_rdy    [DEPTH];
  logic [SRCS_W-1:0]     w_cur_srcs  [DEPTH];
  logic [SRCS_W-1:0]     w_up_srcs   [DEPTH];
  logic [DEPTH-1:0]      w_shift;
  logic [DEPTH-1:0]      w_load;
  logic [DEPTH-1:0]      w_entry_rdy;
  logic [IW-1:0]         w_sel_idx;
  logic                  w_sel_vld;
  logic                  w_fire;
  logic                  w_accept;
  logic [CW-1:0]         w_ins_idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_cur_srcs[g] = op_srcs(r_ent[g].instr);

    if (g < DEPTH - 1) begin : g_up
      assign w_up_ent[g]   = r_ent[g+1];
      assign w_up_valid[g] = r_valid[g+1];
      assign w_up_rdy[g]   = w_rdy[g+1];
      assign w_up_srcs[g]  = w_cur_srcs[g+1];
    end else begin : g_top
      assign w_up_ent[g]   = '0;
      assign w_up_valid[g] = 1'b0;
      assign w_up_rdy[g]   = '0;
      assign w_up_srcs[g]  = '0;
    end

    iq_wakeup #(.NUM_WB(NUM_WB)) u_wakeup (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_load     (w_load[g]),
      .i_shift    (w_shift[g]),
      .i_cur_srcs (w_cur_srcs[g]),
      .i_up_srcs  (w_up_srcs[g]),
      .i_up_rdy   (w_up_rdy[g]),
      .i_new_srcs (op_srcs(in_instr)),
      .i_new_rdy  (in_src_ready),
      .i_wb_addrs (wb_addrs),
      .i_wb_valid (wb_valid),
      .o_rdy      (w_rdy[g])
    );

    assign w_entry_rdy[g] = r_valid[g] & (&w_rdy[g]);
  end

  // Oldest ready entry wins; the in-order variant only ever looks at the head.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    if (IN_ORDER != 0) begin
      w_sel_vld = w_entry_rdy[0];
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (w_entry_rdy[i]) begin
          w_sel_vld = 1'b1;
          w_sel_idx = IW'(i);
        end
      end
    end
  end

  always_comb begin
    w_fire    = w_sel_vld & out_ready;
    in_ready  = (r_count < CW'(DEPTH)) & ~rst;
    w_accept  = in_valid & in_ready & ~flush;
    w_ins_idx = w_fire ? (r_count - CW'(1)) : r_count;
    for (int i = 0; i < DEPTH; i++) begin
      w_shift[i] = w_fire && (IW'(i) >= w_sel_idx);
      w_load[i]  = w_accept && (w_ins_idx == CW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_accept) - CW'(w_fire);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i])       r_valid[i] <= 1'b1;
        else if (w_shift[i]) r_valid[i] <= w_up_valid[i];
      end
    end
  end

  // Payload needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_load[i])       r_ent[i] <= '{instr: in_instr, arch_dest: in_arch_dest};
      else if (w_shift[i]) r_ent[i] <= w_up_ent[i];
    end
  end

  assign out_valid     = w_sel_vld;
  assign out_instr     = r_ent[w_sel_idx].instr;
  assign out_arch_dest = r_ent[w_sel_idx].arch_dest;
  assign occupancy     = r_count;

endmodule
